sm4_ctr_ctrl: RTL and testbench
===============================

Name: sm4_ctr_ctrl

Overview:
Sequencing controller for SM4 CTR mode. Holds session key and counter block. For each data block it restarts round-key generation on the SM4 key module and launches the SM4 core on the current counter block. It then XORs the keystream with the data block and returns it over a valid/ready stream. It sits between the host stream interface and the key-expansion/round-core pair.

Parameters:
CTR_W, 32, width of incrementing counter field (low bits of counter block); 1..128
WDOG_CYC, 64, max cycles in WAIT for core_dout_vld before watchdog abort; >=2

Ports:
clk_sys  in  1  system clock, rising edge
sys_rst  in  1  synchronous reset, active high
cfg_start  in  1  single-cycle pulse: begin session
cfg_key  in  128  session key, sampled on cfg_start
cfg_iv  in  128  initial counter block, sampled on cfg_start
din  in  128  plaintext/ciphertext block
din_vld  in  1  din valid
din_last  in  1  din is final block of session
din_rdy  out  1  controller accepts din
dout  out  128  din XOR keystream
dout_vld  out  1  dout valid
dout_last  out  1  dout is final block
dout_rdy  in  1  downstream accepts dout
key_start  out  1  pulse to key module: start expansion
key_in  out  128  key to key module; zero when key_in_vld=0
key_in_vld  out  1  key_in valid (same cycle as key_start)
core_start  out  1  pulse to SM4 core: start block
core_din  out  128  counter block to core
core_dout  in  128  keystream block from core
core_dout_vld  in  1  keystream valid, single-cycle
busy  out  1  state != IDLE
err_wdog  out  1  sticky watchdog error
blk_cnt  out  CTR_W  blocks completed this session

Behaviour:
- Reset values: every output 0, state IDLE, key/counter/data registers 0, err_wdog 0.
- Counter block ctr[127:0] is registered. Increment: ctr[CTR_W-1:0] += 1 modulo 2^CTR_W; ctr[127:CTR_W] never changes. All-ones wraps to 0 with no flag.
- FSM states: IDLE, READY, ISSUE, WAIT, OUT.
- IDLE:
  - cfg_start=1 -> latch cfg_key, ctr<=cfg_iv, blk_cnt<=0, err_wdog<=0; go READY.
  - din_rdy=0.
- READY:
  - din_rdy=1.
  - din_vld=1 -> latch din and din_last; go ISSUE.
  - cfg_start is ignored in every state except IDLE.
- ISSUE (exactly 1 cycle), registered outputs asserted for this one cycle:
  - key_start=1, key_in_vld=1, key_in=session key.
  - core_start=1, core_din=ctr.
  - Go WAIT; watchdog counter <= 0.
- WAIT:
  - core_dout_vld=1 -> dout <= core_dout ^ latched din, dout_last <= latched last, dout_vld <= 1; increment ctr; blk_cnt += 1; go OUT.
  - Otherwise watchdog += 1. When watchdog reaches WDOG_CYC-1 without core_dout_vld: err_wdog <= 1, go IDLE, discard block, no dout.
- OUT:
  - dout, dout_vld, dout_last held stable until dout_rdy=1.
  - On the handshake cycle: dout_vld <= 0; if dout_last go IDLE, else go READY.
- core_dout_vld outside WAIT is ignored, with no state or counter change.
- din_rdy is 0 outside READY. One block in flight at a time.
- Latency: din accepted at cycle T -> key_start/core_start visible at T+1. dout_vld is visible the cycle after core_dout_vld.
- busy=1 in READY, ISSUE, WAIT, OUT.
- sys_rst mid-operation: return to IDLE the next edge; all outputs are 0 that cycle. An in-flight block is dropped. Any later core_dout_vld is ignored.
- blk_cnt wraps modulo 2^CTR_W.

Test Plan:
1. Standard vector, IV start. cfg_key=cfg_iv=0123456789abcdeffedcba9876543210, din=0, din_last=1, behavioural SM4 core.
   -> core_din=0123456789abcdeffedcba9876543210; dout=681edf34d206965e86b3e94f536e4246, dout_last=1, blk_cnt=1, then IDLE.
2. Two-block session, same key/IV, din=0 then 0. Second issue:
   -> core_din=0123456789abcdeffedcba9876543211; key_start pulses once per block (2 total); blk_cnt=2.
3. Counter wrap. CTR_W=32, cfg_iv=0000..0001_ffffffff.
   -> second core_din=0000..0001_00000000, with upper 96 bits unchanged.
4. Backpressure. Hold dout_rdy=0 for 10 cycles.
   -> dout and dout_vld stable all 10 cycles; din_rdy=0 throughout; one cycle after dout_rdy=1, din_rdy=1.
5. Watchdog. Core stub never asserts core_dout_vld, WDOG_CYC=64.
   -> err_wdog=1 exactly 64 cycles after the WAIT entry edge; busy=0; no dout_vld; next cfg_start clears err_wdog.
6. Reset and ignored inputs.
   -> sys_rst during WAIT: next cycle all outputs 0; a late core_dout_vld produces no dout_vld.
   -> cfg_start while in READY: ctr and key unchanged.

Source files
------------

// File: rtl/sm4_ctr_ctrl.sv
// SM4 CTR-mode sequencer: holds the session key and counter block, launches one
// key expansion plus core block per data block, and XORs the keystream onto the stream.
module sm4_ctr_ctrl #(
   parameter int CTR_W    = 32,
   parameter int WDOG_CYC = 64
) (
   input  logic               clk_sys,
   input  logic               sys_rst,
   input  logic               cfg_start,
   input  logic [127:0]       cfg_key,
   input  logic [127:0]       cfg_iv,
   input  logic [127:0]       din,
   input  logic               din_vld,
   input  logic               din_last,
   output logic               din_rdy,
   output logic [127:0]       dout,
   output logic               dout_vld,
   output logic               dout_last,
   input  logic               dout_rdy,
   output logic               key_start,
   output logic [127:0]       key_in,
   output logic               key_in_vld,
   output logic               core_start,
   output logic [127:0]       core_din,
   input  logic [127:0]       core_dout,
   input  logic               core_dout_vld,
   output logic               busy,
   output logic               err_wdog,
   output logic [CTR_W-1:0]   blk_cnt,
   output logic [2:0]         state_dbg
);

   localparam int WD_W = $clog2(WDOG_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYC - 1);
   // Shifting by 128 yields 0, so CTR_W=128 still produces an all-ones mask.
   localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t            state;
   logic [127:0]      key_q;
   logic [127:0]      ctr;
   logic [127:0]      din_q;
   logic              last_q;
   logic [WD_W-1:0]   wdog;
   logic [127:0]      ctr_inc;

   // Only the low CTR_W bits count; the upper part of the block is fixed per session.
   assign ctr_inc = (ctr & ~CTR_MASK) | ((ctr + 128'd1) & CTR_MASK);

   assign din_rdy   = (state == S_READY);
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk_sys) begin
      if (sys_rst) begin
         state      <= S_IDLE;
         key_q      <= '0;
         ctr        <= '0;
         din_q      <= '0;
         last_q     <= 1'b0;
         wdog       <= '0;
         dout       <= '0;
         dout_vld   <= 1'b0;
         dout_last  <= 1'b0;
         key_start  <= 1'b0;
         key_in     <= '0;
         key_in_vld <= 1'b0;
         core_start <= 1'b0;
         core_din   <= '0;
         err_wdog   <= 1'b0;
         blk_cnt    <= '0;
      end else begin
         // Launch strobes are single-cycle; they only rise on the READY->ISSUE edge.
         key_start  <= 1'b0;
         key_in     <= '0;
         key_in_vld <= 1'b0;
         core_start <= 1'b0;
         core_din   <= '0;
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  key_q    <= cfg_key;
                  ctr      <= cfg_iv;
                  blk_cnt  <= '0;
                  err_wdog <= 1'b0;
                  state    <= S_READY;
               end
            end
            S_READY: begin
               if (din_vld) begin
                  din_q      <= din;
                  last_q     <= din_last;
                  key_start  <= 1'b1;
                  key_in     <= key_q;
                  key_in_vld <= 1'b1;
                  core_start <= 1'b1;
                  core_din   <= ctr;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wdog  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_dout_vld) begin
                  dout      <= core_dout ^ din_q;
                  dout_last <= last_q;
                  dout_vld  <= 1'b1;
                  ctr       <= ctr_inc;
                  blk_cnt   <= blk_cnt + CTR_W'(1);
                  state     <= S_OUT;
               end else if (wdog == WD_MAX) begin
                  err_wdog <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  wdog <= wdog + WD_W'(1);
               end
            end
            S_OUT: begin
               if (dout_rdy) begin
                  dout_vld <= 1'b0;
                  state    <= dout_last ? S_IDLE : S_READY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sm4_ctr_ctrl.sv
// Randomized scoreboard bench for sm4_ctr_ctrl with a behavioural SM4 core stub
// and an independent CTR-mode reference model.
module tb_sm4_ctr_ctrl;

   localparam int CTR_W    = 32;
   localparam int WDOG_CYC = 64;

   logic               clk_sys;
   logic               sys_rst;
   logic               cfg_start;
   logic [127:0]       cfg_key;
   logic [127:0]       cfg_iv;
   logic [127:0]       din;
   logic               din_vld;
   logic               din_last;
   logic               din_rdy;
   logic [127:0]       dout;
   logic               dout_vld;
   logic               dout_last;
   logic               dout_rdy;
   logic               key_start;
   logic [127:0]       key_in;
   logic               key_in_vld;
   logic               core_start;
   logic [127:0]       core_din;
   logic [127:0]       core_dout;
   logic               core_dout_vld;
   logic               busy;
   logic               err_wdog;
   logic [CTR_W-1:0]   blk_cnt;
   logic [2:0]         state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [128:0] exp_q[$];
   logic [127:0] cdin_q[$];
   logic [127:0] sess_key;
   logic [127:0] mdl_ctr;
   int           mdl_blk;
   int           ks_cnt    = 0;
   int           vld_cnt   = 0;
   int           stub_mode = 0;
   bit           rdy_force = 0;
   logic [127:0] last_cdin = '0;

   localparam logic [127:0] VEC = 128'h0123456789abcdeffedcba9876543210;

   localparam logic [2047:0] SBOX_V = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

   sm4_ctr_ctrl #(.CTR_W(CTR_W), .WDOG_CYC(WDOG_CYC)) dut (
      .clk_sys(clk_sys), .sys_rst(sys_rst), .cfg_start(cfg_start), .cfg_key(cfg_key),
      .cfg_iv(cfg_iv), .din(din), .din_vld(din_vld), .din_last(din_last), .din_rdy(din_rdy),
      .dout(dout), .dout_vld(dout_vld), .dout_last(dout_last), .dout_rdy(dout_rdy),
      .key_start(key_start), .key_in(key_in), .key_in_vld(key_in_vld),
      .core_start(core_start), .core_din(core_din), .core_dout(core_dout),
      .core_dout_vld(core_dout_vld), .busy(busy), .err_wdog(err_wdog), .blk_cnt(blk_cnt),
      .state_dbg(state_dbg));

   // ---------------- clock / reset ----------------
   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // ---------------- reference SM4 ----------------
   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX_V[2047 - 8*int'(a) -: 8];
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] w, input int n);
      return (w << n) | (w >> (32 - n));
   endfunction

   function automatic logic [127:0] sm4_enc(input logic [127:0] key, input logic [127:0] blk);
      logic [31:0]  k [0:35];
      logic [31:0]  x [0:35];
      logic [31:0]  rk [0:31];
      logic [31:0]  t;
      logic [31:0]  ck;
      logic [127:0] fk;
      fk = 128'ha3b1bac656aa3350677d9197b27022dc;
      for (int i = 0; i < 4; i++) begin
         k[i] = key[127-32*i -: 32] ^ fk[127-32*i -: 32];
         x[i] = blk[127-32*i -: 32];
      end
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
         t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
         k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
         rk[i] = k[i+4];
      end
      for (int i = 0; i < 32; i++) begin
         t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[i]);
         x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   // Counter field is the low 32 bits; the top 96 bits ride along untouched.
   function automatic logic [127:0] ctr_step(input logic [127:0] c);
      logic [31:0] lo;
      lo = c[31:0] + 32'd1;
      return {c[127:32], lo};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- SM4 core stub ----------------
   initial begin : core_stub
      logic [127:0] stub_key;
      logic [127:0] stub_din;
      bit           pend;
      int           pend_dly;
      stub_key = '0;
      stub_din = '0;
      pend = 0;
      pend_dly = 0;
      core_dout_vld = 1'b0;
      core_dout = '0;
      forever begin
         @(negedge clk_sys);
         core_dout_vld = 1'b0;
         if (key_start) stub_key = key_in;
         if (pend) begin
            if (pend_dly == 0) begin
               core_dout_vld = 1'b1;
               core_dout = sm4_enc(stub_key, stub_din);
               pend = 0;
            end else begin
               pend_dly--;
            end
         end
         if (core_start) begin
            stub_din = core_din;
            if (stub_mode != 1) begin
               pend = 1;
               pend_dly = (stub_mode == 2) ? 5 : $urandom_range(0, 3);
            end
         end
      end
   end

   // ---------------- downstream ready ----------------
   initial begin : rdy_drv
      dout_rdy = 1'b0;
      forever begin
         @(posedge clk_sys);
         #1;
         if (!rdy_force) dout_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic [128:0] e;
      logic [127:0] c;
      forever begin
         @(negedge clk_sys);
         if (!sys_rst) begin
            check("key_in_vld_pairing", key_in_vld, key_start);
            if (!key_in_vld) check("key_in_zero", key_in, 129'd0);
            if (key_start) begin
               ks_cnt++;
               check("key_in", key_in, sess_key);
            end
            if (core_start) begin
               last_cdin = core_din;
               if (cdin_q.size() == 0) check("core_start_unexpected", 1'b1, 1'b0);
               else begin
                  c = cdin_q.pop_front();
                  check("core_din", core_din, c);
               end
            end
            if (dout_vld) vld_cnt++;
            if (dout_vld && dout_rdy) begin
               if (exp_q.size() == 0) check("dout_unexpected", 1'b1, 1'b0);
               else begin
                  e = exp_q.pop_front();
                  check("dout", {dout_last, dout}, e);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_session(input logic [127:0] key, input logic [127:0] iv);
      @(posedge clk_sys);
      #1;
      cfg_key = key;
      cfg_iv = iv;
      cfg_start = 1'b1;
      @(posedge clk_sys);
      #1;
      cfg_start = 1'b0;
      sess_key = key;
      mdl_ctr = iv;
      mdl_blk = 0;
   endtask

   task automatic drive_din(input logic [127:0] data, input logic last);
      bit acc;
      acc = 0;
      @(posedge clk_sys);
      #1;
      din = data;
      din_last = last;
      din_vld = 1'b1;
      for (int i = 0; i < 400 && !acc; i++) begin
         @(negedge clk_sys);
         acc = din_rdy;
         @(posedge clk_sys);
         #1;
      end
      din_vld = 1'b0;
      din_last = 1'b0;
      check("din_accept", acc, 1'b1);
   endtask

   task automatic send_block(input logic [127:0] data, input logic last, input bit expect_out);
      cdin_q.push_back(mdl_ctr);
      if (expect_out) begin
         exp_q.push_back({last, data ^ sm4_enc(sess_key, mdl_ctr)});
         mdl_ctr = ctr_step(mdl_ctr);
         mdl_blk++;
      end
      drive_din(data, last);
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk_sys);
         done = !busy && (exp_q.size() == 0);
      end
      check(name, done, 1'b1);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int ks0;
      int v0;
      int n;
      bit done;
      logic [127:0] cap;
      logic [127:0] k1;
      logic [127:0] iv1;
      sys_rst = 1'b1;
      cfg_start = 1'b0;
      cfg_key = '0;
      cfg_iv = '0;
      din = '0;
      din_vld = 1'b0;
      din_last = 1'b0;
      sess_key = '0;
      mdl_ctr = '0;
      mdl_blk = 0;
      repeat (3) @(posedge clk_sys);
      #1;
      sys_rst = 1'b0;
      @(negedge clk_sys);
      check("rst_dout", {dout_vld, dout}, 129'd0);
      check("rst_dout_last", dout_last, 1'b0);
      check("rst_din_rdy", din_rdy, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err_wdog", err_wdog, 1'b0);
      check("rst_blk_cnt", blk_cnt, 129'd0);
      check("rst_starts", {key_start, core_start, key_in_vld}, 129'd0);
      check("rst_core_din", core_din, 129'd0);
      check("rst_state", state_dbg, 129'd0);

      // Standard vector: din=0 so dout is the SM4 encryption of the IV.
      start_session(VEC, VEC);
      cdin_q.push_back(VEC);
      exp_q.push_back({1'b1, 128'h681edf34d206965e86b3e94f536e4246});
      mdl_ctr = ctr_step(mdl_ctr);
      mdl_blk++;
      drive_din(128'h0, 1'b1);
      wait_idle("vec_idle");
      check("vec_blk_cnt", blk_cnt, 129'd1);
      check("vec_state", state_dbg, 129'd0);

      // Two-block session.
      ks0 = ks_cnt;
      start_session(VEC, VEC);
      send_block(128'h0, 1'b0, 1'b1);
      send_block(128'h0, 1'b1, 1'b1);
      wait_idle("two_idle");
      check("two_core_din2", last_cdin, 128'h0123456789abcdeffedcba9876543211);
      check("two_key_starts", 129'(ks_cnt - ks0), 129'd2);
      check("two_blk_cnt", blk_cnt, 129'd2);

      // Counter wrap in the low 32 bits.
      start_session(rand128(), 128'h00000000_00000000_00000001_ffffffff);
      send_block(rand128(), 1'b0, 1'b1);
      send_block(rand128(), 1'b1, 1'b1);
      wait_idle("wrap_idle");
      check("wrap_core_din2", last_cdin, 128'h00000000_00000000_00000001_00000000);

      // Backpressure on dout.
      rdy_force = 1;
      dout_rdy = 1'b0;
      start_session(rand128(), rand128());
      send_block(rand128(), 1'b0, 1'b1);
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk_sys);
         done = dout_vld;
      end
      check("bp_vld_seen", done, 1'b1);
      cap = dout;
      for (int i = 0; i < 10; i++) begin
         check("bp_vld_hold", dout_vld, 1'b1);
         check("bp_dout_hold", dout, cap);
         check("bp_din_rdy_low", din_rdy, 1'b0);
         @(negedge clk_sys);
      end
      @(posedge clk_sys);
      #1;
      dout_rdy = 1'b1;
      @(posedge clk_sys);
      #1;
      dout_rdy = 1'b0;
      @(negedge clk_sys);
      check("bp_din_rdy_after", din_rdy, 1'b1);
      check("bp_vld_dropped", dout_vld, 1'b0);
      rdy_force = 0;
      send_block(rand128(), 1'b1, 1'b1);
      wait_idle("bp_idle");
      check("bp_blk_cnt", blk_cnt, 129'(mdl_blk));

      // Watchdog abort: the core never answers.
      stub_mode = 1;
      start_session(rand128(), rand128());
      send_block(rand128(), 1'b1, 1'b0);
      @(negedge clk_sys);
      check("wd_core_start", core_start, 1'b1);
      v0 = vld_cnt;
      n = 0;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk_sys);
         n++;
         done = err_wdog;
      end
      check("wd_cycles_after_wait_entry", 129'(n - 1), 129'(WDOG_CYC));
      check("wd_busy", busy, 1'b0);
      check("wd_no_dout", 129'(vld_cnt - v0), 129'd0);
      check("wd_blk_cnt", blk_cnt, 129'd0);
      stub_mode = 0;
      start_session(rand128(), rand128());
      @(negedge clk_sys);
      check("wd_err_cleared", err_wdog, 1'b0);
      check("wd_restart_busy", busy, 1'b1);
      send_block(rand128(), 1'b1, 1'b1);
      wait_idle("wd_recover_idle");

      // Reset while waiting on the core; the late keystream must be ignored.
      stub_mode = 2;
      start_session(rand128(), rand128());
      send_block(rand128(), 1'b1, 1'b0);
      @(posedge clk_sys);
      #1;
      sys_rst = 1'b1;
      @(posedge clk_sys);
      #1;
      sys_rst = 1'b0;
      @(negedge clk_sys);
      check("rstw_dout", {dout_vld, dout}, 129'd0);
      check("rstw_ctrl", {busy, din_rdy, key_start, core_start, key_in_vld, err_wdog, dout_last}, 129'd0);
      check("rstw_blk_cnt", blk_cnt, 129'd0);
      check("rstw_core_din", core_din, 129'd0);
      v0 = vld_cnt;
      repeat (10) @(negedge clk_sys);
      check("rstw_late_vld_ignored", 129'(vld_cnt - v0), 129'd0);
      check("rstw_state", state_dbg, 129'd0);
      stub_mode = 0;

      // cfg_start while READY must not disturb key or counter.
      k1 = rand128();
      iv1 = rand128();
      start_session(k1, iv1);
      @(negedge clk_sys);
      check("ign_in_ready", din_rdy, 1'b1);
      @(posedge clk_sys);
      #1;
      cfg_key = ~k1;
      cfg_iv = ~iv1;
      cfg_start = 1'b1;
      @(posedge clk_sys);
      #1;
      cfg_start = 1'b0;
      send_block(rand128(), 1'b0, 1'b1);
      send_block(rand128(), 1'b1, 1'b1);
      wait_idle("ign_idle");
      check("ign_blk_cnt", blk_cnt, 129'd2);

      // Random sessions.
      for (int s = 0; s < 6; s++) begin
         int nb;
         k1 = rand128();
         iv1 = rand128();
         if ($urandom_range(0, 1) == 1) iv1[31:0] = 32'hffff_fffe;
         start_session(k1, iv1);
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) send_block(rand128(), (b == nb - 1), 1'b1);
         wait_idle("rnd_idle");
         check("rnd_blk_cnt", blk_cnt, 129'(mdl_blk));
      end

      repeat (5) @(negedge clk_sys);
      check("end_exp_q_empty", 129'(exp_q.size()), 129'd0);
      check("end_cdin_q_empty", 129'(cdin_q.size()), 129'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : global_timeout
      #500000;
      failures++;
      $display("FAIL global_timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
